// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and helpers for the multi-sprite renderer.
//   cfg_field_e  - config port field selector
//   fsm_state_e  - per-frame position update FSM states
//   sprite_t     - per-sprite state record
//   rom_addr_w() - width of the {sprite_id, row, col} sprite ROM address
package sprite_pkg;

  localparam int POS_W       = 10;
  localparam int SPR_SPEED_W = 4;
  localparam int SPR_COLOR_W = 3;

  typedef enum logic [2:0] {
    CFG_POSX   = 3'd0,
    CFG_POSY   = 3'd1,
    CFG_SPEEDX = 3'd2,
    CFG_SPEEDY = 3'd3,
    CFG_ENABLE = 3'd4,
    CFG_COLOUR = 3'd5
  } cfg_field_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } fsm_state_e;

  // dirx/diry: 0 = moving towards larger coordinates, 1 = towards smaller
  typedef struct packed {
    logic [POS_W-1:0]       posx;
    logic [POS_W-1:0]       posy;
    logic [SPR_SPEED_W-1:0] speedx;
    logic [SPR_SPEED_W-1:0] speedy;
    logic                   dirx;
    logic                   diry;
    logic                   enable;
    logic [SPR_COLOR_W-1:0] colour;
  } sprite_t;

  // 3 bits of sprite index on top of the in-sprite pixel offset
  function automatic int rom_addr_w(input int w, input int h);
    return $clog2(w * h) + 3;
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: one-axis bounce step, purely combinational.
//   pos_i     - current position
//   speed_i   - pixels per frame
//   dir_i     - 0 = increasing, 1 = decreasing
//   max_pos_i - largest legal position (LIMIT - SIZE)
//   pos_o     - next position, clamped to [0, max_pos_i]
//   dir_o     - next direction, flipped when a wall is hit
module sprite_axis_step
  import sprite_pkg::*;
(
  input  logic [POS_W-1:0]       pos_i,
  input  logic [SPR_SPEED_W-1:0] speed_i,
  input  logic                   dir_i,
  input  logic [POS_W-1:0]       max_pos_i,
  output logic [POS_W-1:0]       pos_o,
  output logic                   dir_o
);

  logic signed [11:0] nxt_s;

  // Signed 12-bit step so that underflow below zero is visible before clamping
  always_comb begin
    if (dir_i) begin
      nxt_s = $signed(12'(pos_i)) - $signed(12'(speed_i));
    end else begin
      nxt_s = $signed(12'(pos_i)) + $signed(12'(speed_i));
    end

    if (nxt_s < 12'sd0) begin
      pos_o = '0;
      dir_o = 1'b0;
    end else if (nxt_s > $signed(12'(max_pos_i))) begin
      pos_o = max_pos_i;
      dir_o = 1'b1;
    end else begin
      pos_o = nxt_s[POS_W-1:0];
      dir_o = dir_i;
    end
  end

endmodule

// File: rtl/multi_sprite_engine.sv
// multi_sprite_engine: N-sprite renderer with autonomous bouncing motion.
//   clk, rst            - pixel clock, synchronous active-low reset
//   pixelx, pixely      - current pixel coordinate
//   frame_start         - one-cycle pulse at start of vertical blank
//   cfg_we/idx/field/data - per-sprite config write port
//   rom_addr, rom_data  - shared sprite ROM, {sprite_id,row,col}; data one cycle later
//   color, is_visible, sprite_id - pixel result, 2 clk after the coordinate
//   collision           - sticky: >=2 sprites covered a pixel this frame
//   overrun             - sticky: frame_start arrived while still updating
module multi_sprite_engine
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 64,
  parameter int SPRITE_H    = 64,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int COLOR_W     = SPR_COLOR_W,
  parameter int SPEED_W     = SPR_SPEED_W
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [9:0]                                 pixelx,
  input  logic [9:0]                                 pixely,
  input  logic                                       frame_start,
  input  logic                                       cfg_we,
  input  logic [2:0]                                 cfg_idx,
  input  logic [2:0]                                 cfg_field,
  input  logic [9:0]                                 cfg_data,
  output logic [rom_addr_w(SPRITE_W, SPRITE_H)-1:0]  rom_addr,
  input  logic                                       rom_data,
  output logic [COLOR_W-1:0]                         color,
  output logic                                       is_visible,
  output logic [2:0]                                 sprite_id,
  output logic                                       collision,
  output logic                                       overrun
);

  localparam int COL_W  = $clog2(SPRITE_W);
  localparam int ROW_W  = $clog2(SPRITE_H);
  localparam int ADDR_W = rom_addr_w(SPRITE_W, SPRITE_H);
  localparam logic [POS_W-1:0] MAX_X = POS_W'(H_ACTIVE - SPRITE_W);
  localparam logic [POS_W-1:0] MAX_Y = POS_W'(V_ACTIVE - SPRITE_H);

  function automatic sprite_t reset_sprite(input int k);
    sprite_t s;
    s.posx   = POS_W'(k * SPRITE_W);
    s.posy   = '0;
    s.speedx = SPR_SPEED_W'(1);
    s.speedy = SPR_SPEED_W'(1);
    s.dirx   = 1'b0;
    s.diry   = 1'b0;
    s.enable = 1'b0;
    s.colour = SPR_COLOR_W'(COLOR_W'(k + 1));
    return s;
  endfunction

  sprite_t    spr_q [NUM_SPRITES];
  sprite_t    spr_d [NUM_SPRITES];
  fsm_state_e st_q, st_d;
  logic [2:0] idx_q, idx_d;
  logic       clr_coll_s, ovr_set_s;

  logic [POS_W-1:0]       cur_posx_s, cur_posy_s;
  logic [SPR_SPEED_W-1:0] cur_spdx_s, cur_spdy_s;
  logic                   cur_dirx_s, cur_diry_s;
  logic [POS_W-1:0]       stx_pos_s, sty_pos_s;
  logic                   stx_dir_s, sty_dir_s;

  logic [NUM_SPRITES-1:0] hit_s;
  logic [3:0]             hit_cnt_s;
  logic [2:0]             win_s;
  logic [POS_W-1:0]       win_posx_s, win_posy_s;
  logic [SPR_COLOR_W-1:0] win_colour_s;
  logic [ROW_W-1:0]       row_s;
  logic [COL_W-1:0]       col_s;

  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               hit_q, hit_d;
  logic [2:0]         id_q, id_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic               coll_q, coll_d;
  logic               ovr_q, ovr_d;
  logic               vis_q, vis_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [2:0]         sid_q;

  // Select the sprite currently being stepped by the update FSM
  always_comb begin
    cur_posx_s = spr_q[0].posx;
    cur_posy_s = spr_q[0].posy;
    cur_spdx_s = spr_q[0].speedx;
    cur_spdy_s = spr_q[0].speedy;
    cur_dirx_s = spr_q[0].dirx;
    cur_diry_s = spr_q[0].diry;
    for (int k = 1; k < NUM_SPRITES; k++) begin
      cur_posx_s = (idx_q == 3'(k)) ? spr_q[k].posx   : cur_posx_s;
      cur_posy_s = (idx_q == 3'(k)) ? spr_q[k].posy   : cur_posy_s;
      cur_spdx_s = (idx_q == 3'(k)) ? spr_q[k].speedx : cur_spdx_s;
      cur_spdy_s = (idx_q == 3'(k)) ? spr_q[k].speedy : cur_spdy_s;
      cur_dirx_s = (idx_q == 3'(k)) ? spr_q[k].dirx   : cur_dirx_s;
      cur_diry_s = (idx_q == 3'(k)) ? spr_q[k].diry   : cur_diry_s;
    end
  end

  sprite_axis_step u_step_x (
    .pos_i     (cur_posx_s),
    .speed_i   (cur_spdx_s),
    .dir_i     (cur_dirx_s),
    .max_pos_i (MAX_X),
    .pos_o     (stx_pos_s),
    .dir_o     (stx_dir_s)
  );

  sprite_axis_step u_step_y (
    .pos_i     (cur_posy_s),
    .speed_i   (cur_spdy_s),
    .dir_i     (cur_diry_s),
    .max_pos_i (MAX_Y),
    .pos_o     (sty_pos_s),
    .dir_o     (sty_dir_s)
  );

  // Update FSM: one sprite per cycle after frame_start, then a DONE cycle
  always_comb begin
    st_d       = st_q;
    idx_d      = idx_q;
    clr_coll_s = 1'b0;
    ovr_set_s  = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (frame_start) begin
          st_d       = ST_UPDATE;
          idx_d      = 3'd0;
          clr_coll_s = 1'b1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        ovr_set_s = frame_start;
        if (idx_q == 3'(NUM_SPRITES - 1)) begin
          st_d = ST_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_DONE: begin
        ovr_set_s = frame_start;
        st_d      = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // Sprite next state: FSM step first, then a config write overrides its field
  always_comb begin
    spr_d = spr_q;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      if ((st_q == ST_UPDATE) && (idx_q == 3'(k)) && spr_q[k].enable) begin
        spr_d[k].posx = stx_pos_s;
        spr_d[k].dirx = stx_dir_s;
        spr_d[k].posy = sty_pos_s;
        spr_d[k].diry = sty_dir_s;
      end else begin
        spr_d[k] = spr_q[k];
      end
      if (cfg_we && (cfg_idx == 3'(k))) begin
        case (cfg_field_e'(cfg_field))
          CFG_POSX:   spr_d[k].posx = (cfg_data > MAX_X) ? MAX_X : cfg_data;
          CFG_POSY:   spr_d[k].posy = (cfg_data > MAX_Y) ? MAX_Y : cfg_data;
          CFG_SPEEDX: begin
            spr_d[k].speedx = SPR_SPEED_W'(cfg_data[SPEED_W-1:0]);
            spr_d[k].dirx   = 1'b0;
          end
          CFG_SPEEDY: begin
            spr_d[k].speedy = SPR_SPEED_W'(cfg_data[SPEED_W-1:0]);
            spr_d[k].diry   = 1'b0;
          end
          CFG_ENABLE: spr_d[k].enable = cfg_data[0];
          CFG_COLOUR: spr_d[k].colour = SPR_COLOR_W'(cfg_data[COLOR_W-1:0]);
          default:    spr_d[k] = spr_d[k];
        endcase
      end else begin
        spr_d[k] = spr_d[k];
      end
    end
  end

  // Hit test per sprite; the 11-bit compare keeps posx+SPRITE_W from wrapping
  always_comb begin
    hit_s = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      hit_s[k] = spr_q[k].enable
        && ({1'b0, pixelx} >= {1'b0, spr_q[k].posx})
        && ({1'b0, pixelx} <  ({1'b0, spr_q[k].posx} + 11'(SPRITE_W)))
        && ({1'b0, pixely} >= {1'b0, spr_q[k].posy})
        && ({1'b0, pixely} <  ({1'b0, spr_q[k].posy} + 11'(SPRITE_H)));
    end
  end

  // Priority select: scanning downwards leaves the lowest-index hit in place
  always_comb begin
    hit_cnt_s    = 4'd0;
    win_s        = 3'd0;
    win_posx_s   = '0;
    win_posy_s   = '0;
    win_colour_s = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      hit_cnt_s    = hit_cnt_s + {3'b000, hit_s[k]};
      win_s        = hit_s[k] ? 3'(k)           : win_s;
      win_posx_s   = hit_s[k] ? spr_q[k].posx   : win_posx_s;
      win_posy_s   = hit_s[k] ? spr_q[k].posy   : win_posy_s;
      win_colour_s = hit_s[k] ? spr_q[k].colour : win_colour_s;
    end
    row_s = ROW_W'(pixely - win_posy_s);
    col_s = COL_W'(pixelx - win_posx_s);
  end

  // Stage 1/2 next values; rom_addr is held when nothing is hit
  always_comb begin
    hit_d      = |hit_s;
    id_d       = hit_d ? win_s : 3'd0;
    colour_d   = hit_d ? win_colour_s[COLOR_W-1:0] : '0;
    rom_addr_d = hit_d ? {win_s, row_s, col_s} : rom_addr_q;
    coll_d     = (clr_coll_s ? 1'b0 : coll_q) | (hit_cnt_s >= 4'd2);
    ovr_d      = ovr_q | ovr_set_s;
    vis_d      = hit_q & rom_data;
    color_d    = vis_d ? colour_q : '0;
  end

  // Sprite table and FSM registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= ST_IDLE;
      idx_q <= 3'd0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
        spr_q[k] <= reset_sprite(k);
      end
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      for (int k = 0; k < NUM_SPRITES; k++) begin
        spr_q[k] <= spr_d[k];
      end
    end
  end

  // Pixel pipeline registers and sticky flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      id_q       <= 3'd0;
      colour_q   <= '0;
      coll_q     <= 1'b0;
      ovr_q      <= 1'b0;
      vis_q      <= 1'b0;
      color_q    <= '0;
      sid_q      <= 3'd0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit_q      <= hit_d;
      id_q       <= id_d;
      colour_q   <= colour_d;
      coll_q     <= coll_d;
      ovr_q      <= ovr_d;
      vis_q      <= vis_d;
      color_q    <= color_d;
      sid_q      <= id_q;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign color      = color_q;
  assign is_visible = vis_q;
  assign sprite_id  = sid_q;
  assign collision  = coll_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_multi_sprite_engine.sv
// Self-checking bench for multi_sprite_engine: directed scenarios plus
// randomized traffic, all compared against a behavioural model.
module tb_multi_sprite_engine;

  localparam int NUM  = 4;
  localparam int SW   = 64;
  localparam int SH   = 64;
  localparam int MAXX = 640 - SW;
  localparam int MAXY = 480 - SH;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  pixelx, pixely;
  logic        frame_start, cfg_we;
  logic [2:0]  cfg_idx, cfg_field;
  logic [9:0]  cfg_data;
  logic [14:0] rom_addr;
  logic        rom_data;
  logic [2:0]  color;
  logic        is_visible;
  logic [2:0]  sprite_id;
  logic        collision, overrun;

  bit rom_mem [0:32767];
  bit rom_all;
  assign rom_data = rom_all ? 1'b1 : rom_mem[rom_addr];

  multi_sprite_engine dut (
    .clk(clk), .rst(rst_n), .pixelx(pixelx), .pixely(pixely),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .rom_addr(rom_addr),
    .rom_data(rom_data), .color(color), .is_visible(is_visible),
    .sprite_id(sprite_id), .collision(collision), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int mpx[NUM], mpy[NUM], msx[NUM], msy[NUM], mdx[NUM], mdy[NUM], men[NUM], mcol[NUM];
  int busy;
  int s1_hit, s1_id, s1_col, e_addr, e_coll, e_ovr, e_vis, e_color, e_sid;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void axis_step(input int p, input int d, input int s, input int lim,
                                    output int np, output int nd);
    int nxt = (d != 0) ? p - s : p + s;
    if (nxt < 0) begin np = 0; nd = 0; end
    else if (nxt > lim) begin np = lim; nd = 1; end
    else begin np = nxt; nd = d; end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM; k++) begin
      mpx[k] = k * SW; mpy[k] = 0; msx[k] = 1; msy[k] = 1;
      mdx[k] = 0; mdy[k] = 0; men[k] = 0; mcol[k] = (k + 1) % 8;
    end
    busy = 0; s1_hit = 0; s1_id = 0; s1_col = 0; e_addr = 0;
    e_coll = 0; e_ovr = 0; e_vis = 0; e_color = 0; e_sid = 0;
  endtask

  // what a clock edge does, given the inputs presented before it
  task automatic model_edge();
    int nh, w, rd, px, py, np, nd, k, d;
    if (!rst_n) begin
      model_reset();
    end else begin
      rd      = rom_all ? 1 : int'(rom_mem[e_addr]);
      e_vis   = (s1_hit != 0 && rd != 0) ? 1 : 0;
      e_color = (e_vis != 0) ? s1_col : 0;
      e_sid   = s1_id;
      px = int'(pixelx); py = int'(pixely);
      nh = 0; w = -1;
      for (int i = 0; i < NUM; i++) begin
        if (men[i] != 0 && px >= mpx[i] && px < mpx[i] + SW && py >= mpy[i] && py < mpy[i] + SH) begin
          nh++;
          if (w < 0) w = i;
        end
      end
      if (frame_start && busy == 0) e_coll = 0;
      if (nh >= 2) e_coll = 1;
      if (w >= 0) begin
        s1_hit = 1; s1_id = w; s1_col = mcol[w];
        e_addr = w * SW * SH + (py - mpy[w]) * SW + (px - mpx[w]);
      end else begin
        s1_hit = 0; s1_id = 0; s1_col = 0;
      end
      if (busy > 0) begin
        if (frame_start) e_ovr = 1;
        k = NUM + 1 - busy;
        if (k < NUM && men[k] != 0) begin
          axis_step(mpx[k], mdx[k], msx[k], MAXX, np, nd); mpx[k] = np; mdx[k] = nd;
          axis_step(mpy[k], mdy[k], msy[k], MAXY, np, nd); mpy[k] = np; mdy[k] = nd;
        end
        busy--;
      end else if (frame_start) begin
        busy = NUM + 1;
      end
      if (cfg_we && int'(cfg_idx) < NUM) begin
        k = int'(cfg_idx); d = int'(cfg_data);
        case (int'(cfg_field))
          0: mpx[k] = (d > MAXX) ? MAXX : d;
          1: mpy[k] = (d > MAXY) ? MAXY : d;
          2: begin msx[k] = d % 16; mdx[k] = 0; end
          3: begin msy[k] = d % 16; mdy[k] = 0; end
          4: men[k] = d % 2;
          5: mcol[k] = d % 8;
          default: ;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("color", int'(color), e_color);
    check_eq("is_visible", int'(is_visible), e_vis);
    check_eq("sprite_id", int'(sprite_id), e_sid);
    check_eq("rom_addr", int'(rom_addr), e_addr);
    check_eq("collision", int'(collision), e_coll);
    check_eq("overrun", int'(overrun), e_ovr);
  endtask

  task automatic cfg(input int idx, input int fld, input int data);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_field = 3'(fld); cfg_data = 10'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    pixelx = 10'(x); pixely = 10'(y);
    tick(); tick();
  endtask

  task automatic frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (NUM + 2) tick();
  endtask

  initial begin
    int px, py, k;
    rst_n = 1'b0; pixelx = '0; pixely = '0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_data = '0;
    rom_all = 1'b1;
    for (int i = 0; i < 32768; i++) rom_mem[i] = 1'($urandom_range(0, 1));
    model_reset();

    // reset state
    tick(); tick();
    check_eq("rst_color", int'(color), 0);
    check_eq("rst_vis", int'(is_visible), 0);
    check_eq("rst_rom_addr", int'(rom_addr), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // single sprite at (100,50)
    cfg(0, 0, 100); cfg(0, 1, 50); cfg(0, 4, 1);
    probe(100, 50);
    check_eq("t1_vis", int'(is_visible), 1);
    check_eq("t1_color", int'(color), 1);
    check_eq("t1_id", int'(sprite_id), 0);
    check_eq("t1_addr", int'(rom_addr), 0);

    // overlap of sprites 0 and 1, collision cleared by next frame
    cfg(0, 0, 200); cfg(0, 1, 200); cfg(1, 0, 180); cfg(1, 1, 190); cfg(1, 4, 1);
    probe(210, 210);
    check_eq("t2_id", int'(sprite_id), 0);
    check_eq("t2_coll", int'(collision), 1);
    probe(639, 0);
    frame();
    check_eq("t2_coll_clr", int'(collision), 0);

    // right-edge bounce of sprite 2
    cfg(0, 4, 0); cfg(1, 4, 0);
    cfg(2, 0, 574); cfg(2, 2, 4); cfg(2, 3, 0); cfg(2, 4, 1);
    frame();
    probe(576, 0);
    check_eq("t3_vis576", int'(is_visible), 1);
    check_eq("t3_id", int'(sprite_id), 2);
    probe(575, 0);
    check_eq("t3_vis575", int'(is_visible), 0);
    frame();
    probe(572, 0);
    check_eq("t3_vis572", int'(is_visible), 1);
    probe(571, 0);
    check_eq("t3_vis571", int'(is_visible), 0);

    // top-edge bounce of sprite 3 (dir made negative by hitting the bottom)
    cfg(3, 1, 414); cfg(3, 3, 5); cfg(3, 2, 0); cfg(3, 4, 1);
    frame();
    cfg(3, 1, 2);
    frame();
    probe(192, 0);
    check_eq("t4_vis_y0", int'(is_visible), 1);
    check_eq("t4_id", int'(sprite_id), 3);
    probe(192, 64);
    check_eq("t4_vis_y64", int'(is_visible), 0);
    frame();
    probe(192, 4);
    check_eq("t4_vis_y4", int'(is_visible), 0);
    probe(192, 5);
    check_eq("t4_vis_y5", int'(is_visible), 1);

    // second frame_start two cycles into an update
    check_eq("t5_ovr_pre", int'(overrun), 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (NUM + 2) tick();
    check_eq("t5_ovr", int'(overrun), 1);
    probe(192, 9);
    check_eq("t5_vis_y9", int'(is_visible), 0);
    probe(192, 10);
    check_eq("t5_vis_y10", int'(is_visible), 1);

    // transparent winner pixel hides the lower-priority sprite beneath
    cfg(0, 0, 300); cfg(0, 1, 300); cfg(0, 4, 1);
    cfg(1, 0, 300); cfg(1, 1, 300); cfg(1, 4, 1);
    rom_all = 1'b0;
    rom_mem[6 * 64 + 5] = 1'b0;
    rom_mem[4096 + 6 * 64 + 5] = 1'b1;
    probe(305, 306);
    check_eq("t6_vis", int'(is_visible), 0);
    check_eq("t6_color", int'(color), 0);
    check_eq("t6_addr", int'(rom_addr), 6 * 64 + 5);
    rom_mem[6 * 64 + 5] = 1'b1;
    probe(305, 306);
    check_eq("t6_vis_opaque", int'(is_visible), 1);

    // reset in the middle of an update
    rom_all = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_eq("t7_coll", int'(collision), 0);
    check_eq("t7_ovr", int'(overrun), 0);
    check_eq("t7_addr", int'(rom_addr), 0);
    probe(0, 0);
    check_eq("t7_none_enabled", int'(is_visible), 0);
    cfg(1, 4, 1);
    probe(64, 0);
    check_eq("t7_vis", int'(is_visible), 1);
    check_eq("t7_color", int'(color), 2);
    check_eq("t7_id", int'(sprite_id), 1);
    frame();
    probe(64, 0);
    check_eq("t7_moved_old", int'(is_visible), 0);
    probe(65, 1);
    check_eq("t7_moved_new", int'(is_visible), 1);

    // randomized traffic against the model
    rom_all = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      cfg(i, 0, int'($urandom_range(0, 700)));
      cfg(i, 1, int'($urandom_range(0, 500)));
      cfg(i, 2, int'($urandom_range(0, 15)));
      cfg(i, 3, int'($urandom_range(0, 15)));
      cfg(i, 4, 1);
    end
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        k  = int'($urandom_range(0, NUM - 1));
        px = mpx[k] + int'($urandom_range(0, SW + 3)) - 2;
        py = mpy[k] + int'($urandom_range(0, SH + 3)) - 2;
        px = (px < 0) ? 0 : px;
        py = (py < 0) ? 0 : py;
      end else begin
        px = int'($urandom_range(0, 1023));
        py = int'($urandom_range(0, 1023));
      end
      pixelx      = 10'(px);
      pixely      = 10'(py);
      frame_start = ($urandom_range(0, 59) == 0);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_idx     = 3'($urandom_range(0, 7));
      cfg_field   = 3'($urandom_range(0, 7));
      cfg_data    = 10'($urandom_range(0, 1023));
      rst_n       = !($urandom_range(0, 1499) == 0);
      tick();
    end
    rst_n = 1'b1; cfg_we = 1'b0; frame_start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_sprite_engine.md
Name: multi_sprite_engine

Overview:
- N-sprite renderer for the VGA graphics path; replaces the single-sprite renderer.
- Per pixel: hit-tests all sprites, picks the lowest-index hit, issues a sprite ROM address, and returns a registered colour and visibility.
- Sprite positions bounce autonomously, updated once per frame by a serial update FSM.
- Per-sprite position, speed, enable and colour are written through a config port.

Parameters:
- NUM_SPRITES, 4, number of sprites (1..8).
- SPRITE_W, 64, sprite width in pixels (power of two).
- SPRITE_H, 64, sprite height in pixels (power of two).
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible rows.
- COLOR_W, 3, colour width.
- SPEED_W, 4, per-axis speed width (pixels/frame).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-low reset.
- pixelx  in  10  current column.
- pixely  in  10  current row.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- cfg_we  in  1  config write strobe.
- cfg_idx  in  3  sprite index.
- cfg_field  in  3  0=posx, 1=posy, 2=speedx, 3=speedy, 4=enable, 5=colour.
- cfg_data  in  10  write data, LSB-aligned.
- rom_addr  out  log2(SPRITE_W*SPRITE_H)+3  {sprite_id, row, col} to shared sprite ROM.
- rom_data  in  1  opaque bit, valid one cycle after rom_addr.
- color  out  COLOR_W  pixel colour, 0 when not visible.
- is_visible  out  1  opaque sprite pixel present.
- sprite_id  out  3  winning sprite index.
- collision  out  1  sticky: two or more sprites overlapped a pixel this frame.
- overrun  out  1  sticky: frame_start arrived while the update FSM was busy.

Behaviour:
- Reset (rst=0 on a clk edge) clears all outputs and state:
  - color=0, is_visible=0, sprite_id=0, rom_addr=0, collision=0, overrun=0, FSM=IDLE.
  - Sprite k: posx=k*SPRITE_W, posy=0, speedx=speedy=1, dirs=+, enable=0, colour=k+1 (truncated to COLOR_W).
  - Reset mid-update aborts the update; positions return to reset values.
- Hit test for sprite k: enable && posx<=pixelx<posx+SPRITE_W && posy<=pixely<posy+SPRITE_H. Compare in 11 bits, with no wrap.
- Pipeline stage 1 (registered):
  - Winner = lowest-index hit.
  - rom_addr = {winner, pixely-posy, pixelx-posx}.
  - hit_d, id_d and colour_d are captured.
  - Any cycle with at least 2 hits sets collision.
- Pipeline stage 2 (registered): is_visible = hit_d && rom_data; color = is_visible ? colour_d : 0; sprite_id = id_d.
- Latency is exactly 2 clk from pixelx/pixely to color/is_visible.
- A transparent winner pixel (rom_data=0) does not fall back to a lower-priority sprite.
- With no hit, rom_addr holds its previous value and outputs go to 0 on the next cycle.
- Update FSM states: IDLE, UPDATE, DONE.
  - IDLE -> UPDATE on frame_start. Also clears collision, sets idx=0.
  - UPDATE processes sprite idx, one sprite per cycle, both axes. Disabled sprites are skipped but still take a cycle.
  - Per axis: nxt = pos ± speed (signed, 12 bits).
    - If nxt<0: pos=0, dir=+.
    - If nxt>LIMIT−SIZE: pos=LIMIT−SIZE, dir=−. LIMIT is H_ACTIVE or V_ACTIVE; SIZE is SPRITE_W or SPRITE_H.
    - Otherwise pos=nxt.
  - idx==NUM_SPRITES−1 -> DONE. DONE -> IDLE next cycle.
  - frame_start in UPDATE or DONE is ignored and sets overrun.
  - overrun is cleared only by reset.
- Config writes:
  - Take effect on the next clk. cfg_idx>=NUM_SPRITES is ignored.
  - Position writes are clamped to LIMIT−SIZE.
  - Writing speedx/speedy also sets that axis dir=+.
  - A write colliding with the FSM update of the same sprite wins for the written field; the other fields update normally.
- speed=0 freezes the axis. A sprite sitting at a clamp edge is stable.

Decomposition:
- Package sprite_pkg holds:
  - the cfg_field enum;
  - the FSM state enum;
  - a sprite_t struct {posx, posy, speedx, speedy, dirx, diry, enable, colour};
  - the ROM address width function.
- One sub-module, sprite_axis_step: combinational pos/speed/dir/limit -> new pos/dir. Instanced twice (x and y) inside the FSM.

Test Plan:
- Reset, then enable sprite0 at (100,50). Drive pixel (100,50) with rom_data=1 -> after 2 clk, is_visible=1, color=1, sprite_id=0, rom_addr={0,0,0}.
- Sprites 0 and 1 overlapping at (200,200), pixel in both -> sprite_id=0, collision=1; collision clears on the next frame_start.
- Sprite2 posx=574, speedx=4, dir + (H_ACTIVE=640), one frame_start -> posx=576, dirx=−; next frame -> posx=572.
- Sprite at posy=2, speedy=5, dir − -> posy=0, diry=+.
- frame_start pulsed again 2 cycles after the first (NUM_SPRITES=4) -> overrun=1, positions advance once only.
- Winner pixel with rom_data=0 and a lower-priority sprite also hit -> is_visible=0, color=0.
- Assert rst=0 during UPDATE -> all state returns to reset values, FSM=IDLE.
